// File: rtl/blob_label_counter.sv
// -----------------------------------------------------------------------------
// blob_label_counter
//   Single-pass connected-component counter for a binary raster image. It
//   consumes one pixel per accepted cycle. Labels are resolved with a
//   root-only parent table, so a single lookup per neighbour always lands on a
//   root. When the frame ends, the table is scanned and the roots whose area
//   reaches the latched minimum are counted.
//
// Ports
//   i_clk          rising-edge clock
//   i_rst_n        asynchronous reset, active low
//   i_frame_start  one-cycle pulse: clear tables and start (or restart) a frame
//   i_data_valid   i_pixel is valid this cycle
//   i_pixel        binary pixel, 1 = foreground
//   i_min_area     minimum qualifying blob area, latched on i_frame_start
//   o_busy         high while streaming or counting
//   o_valid        one-cycle pulse when o_count is final
//   o_count        qualifying blob count (saturating), held until next frame
//   o_overflow     label table ran out this frame (sticky until next frame)
// -----------------------------------------------------------------------------
module blob_label_counter #(
  parameter int IMG_COL = 800,
  parameter int IMG_ROW = 600,
  parameter int LABEL_W = 7,
  parameter int AREA_W  = 16,
  parameter int CNT_W   = 8,
  parameter int CONN8   = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_frame_start,
  input  logic              i_data_valid,
  input  logic              i_pixel,
  input  logic [AREA_W-1:0] i_min_area,
  output logic              o_busy,
  output logic              o_valid,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_overflow
);

  localparam int NLAB  = 1 << LABEL_W;
  localparam int COL_W = (IMG_COL > 1) ? $clog2(IMG_COL) : 1;
  localparam int ROW_W = (IMG_ROW > 1) ? $clog2(IMG_ROW) : 1;
  localparam logic [LABEL_W:0]  MAX_LABEL = (LABEL_W+1)'(NLAB - 1);
  localparam logic [AREA_W-1:0] AREA_MAX  = '1;
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_COUNT, S_DONE} state_t;
  state_t r_state, w_state_next;

  logic [COL_W-1:0]   r_col;
  logic [ROW_W-1:0]   r_row;
  // r_line[0] is the previous pixel, r_line[k] is k+1 pixels back in raster order
  logic [LABEL_W-1:0] r_line   [IMG_COL+1];
  logic [LABEL_W-1:0] r_parent [NLAB];
  logic [AREA_W-1:0]  r_area   [NLAB];
  logic [LABEL_W:0]   r_next_label;
  logic [LABEL_W:0]   r_scan;
  logic [AREA_W-1:0]  r_min_area;
  logic [CNT_W-1:0]   r_count;
  logic               r_overflow;

  // ---------------------------------------------------------------------------
  // Pixel acceptance and position
  // ---------------------------------------------------------------------------
  logic w_consume, w_col_last, w_row_last, w_last_pix, w_fg;
  assign w_consume  = (r_state == S_STREAM) && i_data_valid && !i_frame_start;
  assign w_col_last = (r_col == COL_W'(IMG_COL - 1));
  assign w_row_last = (r_row == ROW_W'(IMG_ROW - 1));
  assign w_last_pix = w_consume && w_col_last && w_row_last;
  assign w_fg       = w_consume && i_pixel;

  // Neighbour labels; positions outside the image read as background
  logic [LABEL_W-1:0] w_n_l, w_n_ul, w_n_u, w_n_ur;
  assign w_n_l  = (r_col != '0) ? r_line[0] : '0;
  assign w_n_ul = (CONN8 != 0 && r_col != '0 && r_row != '0) ? r_line[IMG_COL] : '0;
  assign w_n_u  = (r_row != '0) ? r_line[IMG_COL-1] : '0;
  assign w_n_ur = (CONN8 != 0 && r_row != '0 && !w_col_last) ? r_line[IMG_COL-2] : '0;

  // parent[] only ever holds roots, so one lookup resolves stale labels
  logic [LABEL_W-1:0] w_a, w_b, w_lo, w_hi, w_join_root, w_new_label, w_pix_label;
  assign w_a = (r_parent[w_n_l] != '0) ? r_parent[w_n_l] : r_parent[w_n_ul];
  assign w_b = (r_parent[w_n_u] != '0) ? r_parent[w_n_u] : r_parent[w_n_ur];

  logic w_new, w_alloc, w_join, w_merge;
  assign w_new       = w_fg && (w_a == '0) && (w_b == '0);
  assign w_alloc     = w_new && (r_next_label <= MAX_LABEL);
  assign w_merge     = w_fg && (w_a != '0) && (w_b != '0) && (w_a != w_b);
  assign w_join      = w_fg && !w_new && !w_merge;
  assign w_join_root = (w_a != '0) ? w_a : w_b;
  assign w_lo        = (w_a < w_b) ? w_a : w_b;
  assign w_hi        = (w_a < w_b) ? w_b : w_a;
  assign w_new_label = r_next_label[LABEL_W-1:0];

  always_comb begin
    w_pix_label = '0;
    if (w_alloc)      w_pix_label = w_new_label;
    else if (w_join)  w_pix_label = w_join_root;
    else if (w_merge) w_pix_label = w_lo;
  end

  // Saturating area arithmetic; one extra bit detects the wrap
  logic [AREA_W-1:0] w_area_inc, w_area_sum;
  logic [AREA_W:0]   w_sum_wide;
  assign w_area_inc = (r_area[w_join_root] == AREA_MAX) ? AREA_MAX
                                                        : r_area[w_join_root] + AREA_W'(1);
  assign w_sum_wide = {1'b0, r_area[w_lo]} + {1'b0, r_area[w_hi]} + (AREA_W+1)'(1);
  assign w_area_sum = w_sum_wide[AREA_W] ? AREA_MAX : w_sum_wide[AREA_W-1:0];

  // ---------------------------------------------------------------------------
  // Final count scan
  // ---------------------------------------------------------------------------
  logic [LABEL_W-1:0] w_scan_idx;
  logic               w_scan_last, w_qualifies;
  logic [LABEL_W:0]   w_labels_after;
  assign w_scan_idx     = r_scan[LABEL_W-1:0];
  assign w_scan_last    = (r_scan == r_next_label - (LABEL_W+1)'(1));
  assign w_qualifies    = (r_parent[w_scan_idx] == w_scan_idx) &&
                          (r_area[w_scan_idx] >= r_min_area);
  assign w_labels_after = r_next_label + (LABEL_W+1)'(w_alloc);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    o_busy       = 1'b0;
    o_valid      = 1'b0;
    if (i_frame_start) begin
      w_state_next = S_STREAM;
    end else begin
      case (r_state)
        S_IDLE:   w_state_next = S_IDLE;
        // With no labels allocated the scan is skipped entirely
        S_STREAM: if (w_last_pix)
                    w_state_next = (w_labels_after > (LABEL_W+1)'(1)) ? S_COUNT : S_DONE;
        S_COUNT:  if (w_scan_last) w_state_next = S_DONE;
        S_DONE:   w_state_next = S_IDLE;
        default:  w_state_next = S_IDLE;
      endcase
    end
    o_busy  = (r_state == S_STREAM) || (r_state == S_COUNT);
    o_valid = (r_state == S_DONE);
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_col        <= '0;
      r_row        <= '0;
      r_next_label <= (LABEL_W+1)'(1);
      r_scan       <= (LABEL_W+1)'(1);
      r_min_area   <= '0;
      r_count      <= '0;
      r_overflow   <= 1'b0;
      for (int k = 0; k <= IMG_COL; k++) r_line[k] <= '0;
      for (int k = 0; k < NLAB; k++) begin
        r_parent[k] <= '0;
        r_area[k]   <= '0;
      end
    end else if (i_frame_start) begin
      r_col        <= '0;
      r_row        <= '0;
      r_next_label <= (LABEL_W+1)'(1);
      r_scan       <= (LABEL_W+1)'(1);
      r_min_area   <= i_min_area;
      r_count      <= '0;
      r_overflow   <= 1'b0;
      for (int k = 0; k <= IMG_COL; k++) r_line[k] <= '0;
      for (int k = 0; k < NLAB; k++) begin
        r_parent[k] <= '0;
        r_area[k]   <= '0;
      end
    end else begin
      if (w_consume) begin
        r_line[0] <= w_pix_label;
        for (int k = 1; k <= IMG_COL; k++) r_line[k] <= r_line[k-1];
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : r_row + ROW_W'(1);
        end else begin
          r_col <= r_col + COL_W'(1);
        end
      end
      if (w_new && !w_alloc) r_overflow <= 1'b1;
      if (w_alloc) begin
        r_parent[w_new_label] <= w_new_label;
        r_area[w_new_label]   <= AREA_W'(1);
        r_next_label          <= r_next_label + (LABEL_W+1)'(1);
      end
      if (w_join) r_area[w_join_root] <= w_area_inc;
      if (w_merge) begin
        // Redirect every label rooted at hi so parent[] stays root-only
        for (int k = 0; k < NLAB; k++)
          if (r_parent[k] == w_hi) r_parent[k] <= w_lo;
        r_area[w_lo] <= w_area_sum;
        r_area[w_hi] <= '0;
      end
      if (r_state == S_COUNT) begin
        if (w_qualifies && r_count != CNT_MAX) r_count <= r_count + CNT_W'(1);
        r_scan <= r_scan + (LABEL_W+1)'(1);
      end
    end
  end

  assign o_count    = r_count;
  assign o_overflow = r_overflow;

endmodule

// File: tb/tb_blob_label_counter.sv
// -----------------------------------------------------------------------------
// tb_blob_label_counter
//   Directed bench for an 8x6 image with 3-bit labels. Two instances share the
//   stimulus: dut_a uses 8-connectivity and dut_b uses 4-connectivity. Every
//   expected value below was worked out by hand from the test images.
// -----------------------------------------------------------------------------
module tb_blob_label_counter;

  localparam int AW = 8;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          frame_start = 1'b0;
  logic          data_valid = 1'b0;
  logic          pixel = 1'b0;
  logic [AW-1:0] min_area = '0;
  logic          busy_a, valid_a, ovf_a, busy_b, valid_b, ovf_b;
  logic [CW-1:0] count_a, count_b;

  int total = 0;
  int bad = 0;
  int vcnt_a = 0;
  int vcnt_b = 0;

  always #5 clk = ~clk;

  blob_label_counter #(.IMG_COL(8), .IMG_ROW(6), .LABEL_W(3), .AREA_W(AW),
                       .CNT_W(CW), .CONN8(1)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_frame_start(frame_start),
    .i_data_valid(data_valid), .i_pixel(pixel), .i_min_area(min_area),
    .o_busy(busy_a), .o_valid(valid_a), .o_count(count_a), .o_overflow(ovf_a));

  blob_label_counter #(.IMG_COL(8), .IMG_ROW(6), .LABEL_W(3), .AREA_W(AW),
                       .CNT_W(CW), .CONN8(0)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_frame_start(frame_start),
    .i_data_valid(data_valid), .i_pixel(pixel), .i_min_area(min_area),
    .o_busy(busy_b), .o_valid(valid_b), .o_count(count_b), .o_overflow(ovf_b));

  // Count o_valid pulses on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (valid_a) vcnt_a++;
    if (valid_b) vcnt_b++;
  end

  // Images: bit index = row*8 + col
  function automatic logic [47:0] img_ushape();
    logic [47:0] m;
    m = '0;
    for (int r = 0; r < 5; r++) begin
      m[r*8+1] = 1'b1;
      m[r*8+5] = 1'b1;
    end
    for (int c = 1; c <= 5; c++) m[32+c] = 1'b1;
    return m;
  endfunction

  // Starts a frame (pixel offered alongside the start pulse must be ignored),
  // streams 48 pixels with optional random gaps, then waits for both results.
  task automatic run_frame(input logic [47:0] img, input logic [AW-1:0] ma,
                           input int gap_pct, output bit timed_out,
                           output bit ev_a, output bit ev_b);
    int va0, vb0;
    va0 = vcnt_a;
    vb0 = vcnt_b;
    @(posedge clk); #1;
    frame_start = 1'b1; min_area = ma; data_valid = 1'b1; pixel = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0; data_valid = 1'b0;
    for (int p = 0; p < 48; p++) begin
      while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
        data_valid = 1'b0;
        @(posedge clk); #1;
      end
      data_valid = 1'b1;
      pixel = img[p];
      @(posedge clk); #1;
    end
    data_valid = 1'b0;
    pixel = 1'b0;
    ev_a = valid_a;
    ev_b = valid_b;
    for (int i = 0; i < 200 && !(vcnt_a > va0 && vcnt_b > vb0); i++) @(posedge clk);
    timed_out = !(vcnt_a > va0 && vcnt_b > vb0);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (busy_a !== 1'b0 || busy_b !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b/%b expected 0/0", busy_a, busy_b); end
    total++; if (valid_a !== 1'b0 || valid_b !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b/%b expected 0/0", valid_a, valid_b); end
    total++; if (count_a !== 8'd0 || count_b !== 8'd0) begin bad++; $display("FAIL reset_count: got %0d/%0d expected 0/0", count_a, count_b); end
    total++; if (ovf_a !== 1'b0 || ovf_b !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b/%b expected 0/0", ovf_a, ovf_b); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    $display("reset: checked");
  endtask

  task automatic test_all_zero();
    bit to, ea, eb;
    run_frame('0, 8'd0, 0, to, ea, eb);
    total++; if (to) begin bad++; $display("FAIL zero_timeout: got no o_valid expected pulse"); end
    total++; if (ea !== 1'b1 || eb !== 1'b1) begin bad++; $display("FAIL zero_latency: got valid %b/%b one cycle after last pixel expected 1/1", ea, eb); end
    total++; if (count_a !== 8'd0 || count_b !== 8'd0) begin bad++; $display("FAIL zero_count: got %0d/%0d expected 0/0", count_a, count_b); end
    total++; if (ovf_a !== 1'b0 || ovf_b !== 1'b0) begin bad++; $display("FAIL zero_ovf: got %b/%b expected 0/0", ovf_a, ovf_b); end
    $display("all_zero: count %0d/%0d", count_a, count_b);
  endtask

  task automatic test_ushape();
    bit to, ea, eb;
    // Single merged blob of area 13: qualifies at min 13, not at min 14
    run_frame(img_ushape(), 8'd13, 0, to, ea, eb);
    total++; if (to) begin bad++; $display("FAIL ushape13_timeout: got no o_valid expected pulse"); end
    total++; if (count_a !== 8'd1 || count_b !== 8'd1) begin bad++; $display("FAIL ushape13_count: got %0d/%0d expected 1/1", count_a, count_b); end
    $display("ushape min13: count %0d/%0d", count_a, count_b);
    run_frame(img_ushape(), 8'd14, 0, to, ea, eb);
    total++; if (to) begin bad++; $display("FAIL ushape14_timeout: got no o_valid expected pulse"); end
    total++; if (count_a !== 8'd0 || count_b !== 8'd0) begin bad++; $display("FAIL ushape14_count: got %0d/%0d expected 0/0", count_a, count_b); end
    $display("ushape min14: count %0d/%0d", count_a, count_b);
  endtask

  task automatic test_diag();
    bit to, ea, eb;
    logic [47:0] m;
    m = '0;
    m[0] = 1'b1; m[9] = 1'b1; m[18] = 1'b1;
    run_frame(m, 8'd0, 0, to, ea, eb);
    total++; if (to) begin bad++; $display("FAIL diag_timeout: got no o_valid expected pulse"); end
    total++; if (count_a !== 8'd1) begin bad++; $display("FAIL diag_conn8: got %0d expected 1", count_a); end
    total++; if (count_b !== 8'd3) begin bad++; $display("FAIL diag_conn4: got %0d expected 3", count_b); end
    $display("diag: count %0d/%0d", count_a, count_b);
  endtask

  task automatic test_min_area();
    bit to, ea, eb;
    logic [47:0] m;
    logic [AW-1:0] mins [3];
    logic [CW-1:0] exps [3];
    m = '0;
    m[0] = 1'b1;                                   // area 1
    for (int c = 3; c <= 5; c++) m[c] = 1'b1;      // area 3
    for (int c = 0; c <= 4; c++) m[24+c] = 1'b1;   // area 5
    mins[0] = 8'd3; exps[0] = 8'd2;
    mins[1] = 8'd6; exps[1] = 8'd0;
    mins[2] = 8'd1; exps[2] = 8'd3;
    for (int i = 0; i < 3; i++) begin
      run_frame(m, mins[i], 0, to, ea, eb);
      total++; if (to) begin bad++; $display("FAIL minarea_timeout[%0d]: got no o_valid expected pulse", i); end
      total++; if (count_a !== exps[i] || count_b !== exps[i]) begin bad++; $display("FAIL minarea_count[min=%0d]: got %0d/%0d expected %0d", mins[i], count_a, count_b, exps[i]); end
      $display("min_area %0d: count %0d/%0d", mins[i], count_a, count_b);
    end
  endtask

  task automatic test_overflow();
    bit to, ea, eb;
    logic [47:0] m;
    m = '0;
    for (int r = 0; r < 6; r += 2)
      for (int c = 0; c < 6; c += 2) m[r*8+c] = 1'b1;
    run_frame(m, 8'd0, 0, to, ea, eb);
    total++; if (to) begin bad++; $display("FAIL ovf_timeout: got no o_valid expected pulse"); end
    total++; if (ovf_a !== 1'b1 || ovf_b !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b/%b expected 1/1", ovf_a, ovf_b); end
    total++; if (count_a !== 8'd7 || count_b !== 8'd7) begin bad++; $display("FAIL ovf_count: got %0d/%0d expected 7/7", count_a, count_b); end
    $display("overflow: count %0d/%0d ovf %b/%b", count_a, count_b, ovf_a, ovf_b);
  endtask

  task automatic test_reset_mid();
    int va0, vb0;
    va0 = vcnt_a;
    vb0 = vcnt_b;
    @(posedge clk); #1;
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    total++; if (busy_a !== 1'b1 || busy_b !== 1'b1) begin bad++; $display("FAIL busy_after_start: got %b/%b expected 1/1", busy_a, busy_b); end
    for (int p = 0; p < 10; p++) begin
      data_valid = 1'b1; pixel = p[0];
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    total++; if (busy_a !== 1'b0 || busy_b !== 1'b0) begin bad++; $display("FAIL midreset_busy: got %b/%b expected 0/0", busy_a, busy_b); end
    total++; if (count_a !== 8'd0 || count_b !== 8'd0) begin bad++; $display("FAIL midreset_count: got %0d/%0d expected 0/0", count_a, count_b); end
    total++; if (ovf_a !== 1'b0 || ovf_b !== 1'b0) begin bad++; $display("FAIL midreset_ovf: got %b/%b expected 0/0", ovf_a, ovf_b); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    data_valid = 1'b0;
    total++; if (vcnt_a != va0 || vcnt_b != vb0) begin bad++; $display("FAIL midreset_novalid: got %0d/%0d pulses expected 0/0", vcnt_a - va0, vcnt_b - vb0); end
    $display("reset_mid: busy %b/%b", busy_a, busy_b);
  endtask

  task automatic test_back_to_back();
    bit to, ea, eb;
    int va0, vb0;
    logic [47:0] m;
    m = img_ushape();
    va0 = vcnt_a;
    vb0 = vcnt_b;
    @(posedge clk); #1;
    frame_start = 1'b1; min_area = 8'd0;
    @(posedge clk); #1;
    frame_start = 1'b0;
    // Partial frame with gaps, abandoned by a restart
    for (int p = 0; p < 20; p++) begin
      while ($urandom_range(1) == 0) begin
        data_valid = 1'b0;
        @(posedge clk); #1;
      end
      data_valid = 1'b1; pixel = m[p];
      @(posedge clk); #1;
    end
    run_frame(m, 8'd0, 50, to, ea, eb);
    repeat (5) @(posedge clk);
    #1;
    total++; if (to) begin bad++; $display("FAIL gaps_timeout: got no o_valid expected pulse"); end
    total++; if (count_a !== 8'd1 || count_b !== 8'd1) begin bad++; $display("FAIL gaps_count: got %0d/%0d expected 1/1", count_a, count_b); end
    total++; if (ovf_a !== 1'b0 || ovf_b !== 1'b0) begin bad++; $display("FAIL gaps_ovf: got %b/%b expected 0/0", ovf_a, ovf_b); end
    total++; if (vcnt_a - va0 != 1 || vcnt_b - vb0 != 1) begin bad++; $display("FAIL gaps_pulses: got %0d/%0d expected 1/1", vcnt_a - va0, vcnt_b - vb0); end
    total++; if (busy_a !== 1'b0 || busy_b !== 1'b0) begin bad++; $display("FAIL gaps_busy_after: got %b/%b expected 0/0", busy_a, busy_b); end
    $display("back_to_back: count %0d/%0d pulses %0d/%0d", count_a, count_b, vcnt_a - va0, vcnt_b - vb0);
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_ushape();
    test_diag();
    test_min_area();
    test_overflow();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/blob_label_counter.md
Name: blob_label_counter

Overview:
- Streaming single-pass connected-component counter for a binary image, one pixel per accepted cycle, in raster order.
- Generalises the blob pipeline with:
  - parametrised image size, label depth, area and count widths;
  - selectable 4/8-connectivity;
  - a runtime minimum-area filter;
  - label-overflow reporting.
- Sits after the camera binarisation stage.
- Reports the number of qualifying blobs once per frame.

Parameters:
- IMG_COL, 800, pixels per row.
- IMG_ROW, 600, rows per frame.
- LABEL_W, 7, label width. Labels run 1..2^LABEL_W-1; label 0 means background.
- AREA_W, 16, per-label area accumulator width. Saturates.
- CNT_W, 8, blob count width. Saturates.
- CONN8, 1, connectivity: 1 = 8-connectivity, 0 = 4-connectivity.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous reset, active low.
- i_frame_start  in  1  one-cycle pulse; starts or restarts a frame.
- i_data_valid  in  1  i_pixel is valid this cycle.
- i_pixel  in  1  binary pixel; 1 = foreground.
- i_min_area  in  AREA_W  minimum blob area; sampled on i_frame_start.
- o_busy  out  1  high from frame start until o_valid.
- o_valid  out  1  one-cycle pulse when o_count is final.
- o_count  out  CNT_W  qualifying blob count; held until the next i_frame_start.
- o_overflow  out  1  label table exhausted this frame; sticky until the next i_frame_start.

Behaviour:
- Reset values: o_busy=0, o_valid=0, o_count=0, o_overflow=0. State=IDLE, all label tables cleared.
- State machine: IDLE -> STREAM -> COUNT -> DONE -> IDLE.
- i_frame_start, in any state (including mid-STREAM or mid-COUNT):
  - clears line buffer, parent table, area table, next_label=1, o_count, o_overflow;
  - latches i_min_area;
  - enters STREAM; o_busy=1 on the next cycle.
- STREAM:
  - a pixel is consumed only when i_data_valid=1; gaps stall all counters.
  - Column/row counters wrap at IMG_COL-1 and IMG_ROW-1.
  - After pixel IMG_ROW*IMG_COL-1 is consumed, go to COUNT.
  - i_pixel is ignored outside STREAM.
- Line buffer: holds IMG_COL+1 labels (previous row plus up-left). Background pixels write label 0.
- Neighbours:
  - L = left, UL = up-left, U = up, UR = up-right.
  - Out-of-image neighbours read as 0: column 0 has no L/UL, column IMG_COL-1 has no UR, row 0 has no UL/U/UR.
  - CONN8=0 forces UL=UR=0.
- Root lookup: every neighbour label x is replaced by parent[x].
  - Invariant: parent[x] is always a root, so one lookup suffices.
- Candidates: A = L if nonzero, else UL. B = U if nonzero, else UR. At most one merge per pixel.
- Foreground pixel, both A and B zero:
  - if next_label <= 2^LABEL_W-1: assign next_label, parent[new]=new, area[new]=1, next_label++;
  - else: assign label 0, set o_overflow=1, pixel is dropped.
- Foreground pixel, exactly one candidate nonzero, or both with equal roots: assign that root r; area[r]++.
- Foreground pixel, roots differ (lo = min root, hi = max root), all in the same cycle:
  - every entry k with parent[k]==hi is rewritten to lo, in parallel;
  - area[lo] = area[lo] + area[hi] + 1, saturating;
  - area[hi] = 0;
  - pixel is assigned lo.
- Retired labels are never reused within a frame.
- Area arithmetic is AREA_W bits and saturates at 2^AREA_W-1.
- COUNT:
  - scan k = 1..next_label-1, one entry per cycle;
  - count++ when parent[k]==k and area[k] >= min_area;
  - count saturates at 2^CNT_W-1.
  - Latency is next_label-1 cycles; zero cycles if no labels were allocated.
- DONE (one cycle): o_valid=1, o_count=count, o_busy=0, then IDLE. o_count is held until the next i_frame_start.
- min_area=0 or min_area=1 counts every root.
- Simultaneous i_frame_start and i_data_valid: the frame starts; that pixel is not consumed.
- Asynchronous reset mid-frame: returns immediately to reset values and produces no o_valid.

Test Plan (IMG_COL=8, IMG_ROW=6, LABEL_W=3, unless noted):
1. All-zero frame, i_min_area=0 -> o_valid exactly 1 cycle after the 48th accepted pixel; o_count=0, o_overflow=0.
2. CONN8=0, U-shape (columns 1 and 5 filled in rows 0-4, row 4 filled across columns 1-5) -> two labels merge at row 4; o_count=1, single root area=13.
3. Diagonal pixels at (0,0),(1,1),(2,2): CONN8=1 -> o_count=1; CONN8=0 -> o_count=3.
4. Isolated blobs of area 1, 3 and 5 with i_min_area=3 -> o_count=2. Same frame with i_min_area=6 -> o_count=0.
5. CONN8=0, nine isolated single pixels -> o_overflow=1, o_count=7, last two pixels dropped.
6. Pseudo-random i_data_valid gaps (about 50% duty), plus i_frame_start pulsed after 20 pixels and then a full frame -> o_count matches the gap-free run; exactly one o_valid pulse.
